// File: rtl/float_multiply_fp32.sv
// Two-stage binary32 multiplier: stage 1 classifies operands and forms the raw
// significand product, stage 2 normalizes, rounds to nearest-even and packs.
module float_multiply_fp32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IN1,
  input  logic [31:0] IN2,
  output logic [31:0] OUT
);

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_NAN    = 2'd1,
    CLS_INF    = 2'd2,
    CLS_ZERO   = 2'd3
  } op_class_e;

  logic [7:0]  a_exp, b_exp;
  logic [22:0] a_frac, b_frac;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  logic               sign_d, sign_q;
  op_class_e          cls_d, cls_q;
  logic signed [9:0]  exp_d, exp_q;
  logic [47:0]        prod_d, prod_q;
  logic [31:0]        out_d, out_q;

  logic [22:0]        mant;
  logic               guard, sticky, round_up;
  logic [23:0]        mant_rnd;
  logic signed [9:0]  exp_norm, exp_rnd;

  assign a_exp  = IN1[30:23];
  assign b_exp  = IN2[30:23];
  assign a_frac = IN1[22:0];
  assign b_frac = IN2[22:0];

  // Subnormal operands are flushed: any zero exponent counts as zero.
  assign a_zero = (a_exp == 8'd0);
  assign b_zero = (b_exp == 8'd0);
  assign a_inf  = (a_exp == 8'hFF) && (a_frac == 23'd0);
  assign b_inf  = (b_exp == 8'hFF) && (b_frac == 23'd0);
  assign a_nan  = (a_exp == 8'hFF) && (a_frac != 23'd0);
  assign b_nan  = (b_exp == 8'hFF) && (b_frac != 23'd0);

  always_comb begin
    sign_d = IN1[31] ^ IN2[31];
    cls_d  = CLS_NORMAL;
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
      cls_d = CLS_NAN;
    end else if (a_inf || b_inf) begin
      cls_d = CLS_INF;
    end else if (a_zero || b_zero) begin
      cls_d = CLS_ZERO;
    end
    exp_d  = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - 10'sd127;
    prod_d = {24'd0, 1'b1, a_frac} * {24'd0, 1'b1, b_frac};
  end

  // The product of two [1,2) significands lies in [1,4); bit 47 selects the shift.
  always_comb begin
    if (prod_q[47]) begin
      mant     = prod_q[46:24];
      guard    = prod_q[23];
      sticky   = |prod_q[22:0];
      exp_norm = exp_q + 10'sd1;
    end else begin
      mant     = prod_q[45:23];
      guard    = prod_q[22];
      sticky   = |prod_q[21:0];
      exp_norm = exp_q;
    end
    round_up = guard & (sticky | mant[0]);
    mant_rnd = {1'b0, mant} + {23'd0, round_up};
    exp_rnd  = exp_norm + (mant_rnd[23] ? 10'sd1 : 10'sd0);

    out_d = 32'h0000_0000;
    case (cls_q)
      CLS_NAN:  out_d = 32'h7FC0_0000;
      CLS_INF:  out_d = {sign_q, 8'hFF, 23'h0};
      CLS_ZERO: out_d = {sign_q, 31'h0};
      default: begin
        if (exp_rnd >= 10'sd255) begin
          out_d = {sign_q, 8'hFF, 23'h0};
        end else if (exp_rnd <= 10'sd0) begin
          out_d = {sign_q, 31'h0};
        end else begin
          out_d = {sign_q, exp_rnd[7:0], mant_rnd[22:0]};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      cls_q  <= CLS_ZERO;
      exp_q  <= 10'sd0;
      prod_q <= 48'd0;
      out_q  <= 32'h0000_0000;
    end else begin
      sign_q <= sign_d;
      cls_q  <= cls_d;
      exp_q  <= exp_d;
      prod_q <= prod_d;
      out_q  <= out_d;
    end
  end

  assign OUT = out_q;

endmodule

// File: tb/tb_float_multiply_fp32.sv
// Self-checking bench for float_multiply_fp32: directed vectors with literal
// expectations plus an arithmetic reference model checked on every cycle.
module tb_float_multiply_fp32;

  logic        clk;
  logic        rst_n;
  logic [31:0] IN1;
  logic [31:0] IN2;
  logic [31:0] OUT;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] pend[$];
  logic [31:0] exp_now = 32'h0;

  float_multiply_fp32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .IN1   (IN1),
    .IN2   (IN2),
    .OUT   (OUT)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Reference: exact integer product, locate its leading one, then round the
  // discarded remainder against exactly one half ULP.
  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    int                ea, eb, msb, sh, uexp, be;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    longint unsigned   ma, mb, p, q, rem, half;
    s      = a[31] ^ b[31];
    ea     = int'(a[30:23]);
    eb     = int'(b[30:23]);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_inf  = (ea == 255) && (a[22:0] == 23'd0);
    b_inf  = (eb == 255) && (b[22:0] == 23'd0);
    a_nan  = (ea == 255) && (a[22:0] != 23'd0);
    b_nan  = (eb == 255) && (b[22:0] != 23'd0);
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) return 32'h7FC0_0000;
    if (a_inf || b_inf) return {s, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {s, 31'h0};
    ma  = {40'd0, 1'b1, a[22:0]};
    mb  = {40'd0, 1'b1, b[22:0]};
    p   = ma * mb;
    msb = 0;
    for (int i = 0; i < 64; i++) if (p[i]) msb = i;
    sh   = msb - 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    uexp = (ea - 127) + (eb - 127) + (msb - 46);
    if (q == (64'd1 << 24)) begin
      q    = q >> 1;
      uexp = uexp + 1;
    end
    be = uexp + 127;
    if (be >= 255) return {s, 8'hFF, 23'h0};
    if (be <= 0) return {s, 31'h0};
    return {s, 8'(be), q[22:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    IN1 = a;
    IN2 = b;
  endtask

  // Expected OUT after each edge: the model of whatever was sampled one edge earlier.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      exp_now = 32'h0;
    end else begin
      if (pend.size() > 0) exp_now = pend.pop_front();
      else exp_now = 32'h0;
      pend.push_back(model_mul(IN1, IN2));
    end
  end

  always @(negedge clk) checkOutput("stream", OUT, exp_now);

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] dir_a [0:9];
  logic [31:0] dir_b [0:9];
  logic [31:0] dir_r [0:9];
  logic [31:0] pipe_a [0:3];
  logic [31:0] pipe_b [0:3];
  logic [31:0] pipe_r [0:3];

  initial begin
    dir_a[0] = 32'h415A0000; dir_b[0] = 32'hBE200000; dir_r[0] = 32'hC0084000;
    dir_a[1] = 32'h7F800000; dir_b[1] = 32'h00000000; dir_r[1] = 32'h7FC00000;
    dir_a[2] = 32'hFF800000; dir_b[2] = 32'h40000000; dir_r[2] = 32'hFF800000;
    dir_a[3] = 32'h80000000; dir_b[3] = 32'h3F800000; dir_r[3] = 32'h80000000;
    dir_a[4] = 32'h00400000; dir_b[4] = 32'h3F800000; dir_r[4] = 32'h00000000;
    dir_a[5] = 32'h7F000000; dir_b[5] = 32'h40000000; dir_r[5] = 32'h7F800000;
    dir_a[6] = 32'h00800000; dir_b[6] = 32'h3F000000; dir_r[6] = 32'h00000000;
    dir_a[7] = 32'h3F800001; dir_b[7] = 32'h3F800001; dir_r[7] = 32'h3F800002;
    dir_a[8] = 32'h3FFFFFFF; dir_b[8] = 32'h3FFFFFFF; dir_r[8] = 32'h407FFFFE;
    dir_a[9] = 32'h3F800000; dir_b[9] = 32'h3F800000; dir_r[9] = 32'h3F800000;

    pipe_a[0] = 32'h40000000; pipe_b[0] = 32'h40400000; pipe_r[0] = 32'h40C00000;
    pipe_a[1] = 32'h3FC00000; pipe_b[1] = 32'h3FC00000; pipe_r[1] = 32'h40100000;
    pipe_a[2] = 32'hC0A00000; pipe_b[2] = 32'h3E800000; pipe_r[2] = 32'hBFA00000;
    pipe_a[3] = 32'h42C80000; pipe_b[3] = 32'h42C80000; pipe_r[3] = 32'h461C4000;

    for (int i = 0; i < 10; i++) checkOutput("model_pin", model_mul(dir_a[i], dir_b[i]), dir_r[i]);

    // Reset with the first test-plan operands held constant.
    rst_n = 1'b0;
    applyStimulus(32'h415A0000, 32'hBE200000);
    repeat (2) @(negedge clk);
    checkOutput("in_reset", OUT, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release_edge1", OUT, 32'h0);
    @(negedge clk);
    checkOutput("release_edge2", OUT, 32'hC0084000);
    repeat (3) @(negedge clk);
    checkOutput("held_stable", OUT, 32'hC0084000);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(dir_a[i], dir_b[i]);
      repeat (2) @(negedge clk);
      checkOutput("directed", OUT, dir_r[i]);
    end

    // Four different pairs on consecutive cycles; each result one cycle apart.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) applyStimulus(pipe_a[i], pipe_b[i]);
      @(negedge clk);
      if (i >= 1) checkOutput("pipeline", OUT, pipe_r[i-1]);
    end

    for (int i = 0; i < 200; i++) begin
      logic [31:0] ra, rb;
      ra = {1'(($urandom_range(0, 1))), 8'($urandom_range(100, 154)), 23'($urandom)};
      rb = {1'(($urandom_range(0, 1))), 8'($urandom_range(100, 154)), 23'($urandom)};
      if (i % 17 == 5) ra = {ra[31], 8'hFE, ra[22:0]};
      if (i % 19 == 7) rb = {rb[31], 8'h01, rb[22:0]};
      applyStimulus(ra, rb);
      @(negedge clk);
    end

    // Asynchronous reset between edges while results stream.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(pipe_a[i], pipe_b[i]);
      @(negedge clk);
    end
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", OUT, 32'h0);
    applyStimulus(32'h3F800000, 32'h40400000);
    @(negedge clk);
    @(posedge clk);
    #10;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("after_release0", OUT, 32'h0);
    @(negedge clk);
    checkOutput("after_release1", OUT, 32'h0);
    @(negedge clk);
    checkOutput("after_release2", OUT, 32'h40400000);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/float_multiply_fp32.md
# float_multiply_fp32

A pipelined IEEE-754 single-precision (binary32) floating-point multiplier. It accepts one operand pair every clock and produces the rounded product two clocks later. It sits in the datapath as a standalone arithmetic unit with no handshake: operands are sampled every cycle, and results stream out in the same order. Subnormals are flushed to zero, and rounding is round-to-nearest-even.

## Interface
- No parameters; width is fixed at 32 bits (binary32).
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- IN1  input  32  operand A, binary32 (sign[31], exp[30:23], frac[22:0]).
- IN2  input  32  operand B, binary32.
- OUT  output  32  registered product A×B, binary32.

## Operation
- Decode:
  - sign = A[31] ^ B[31].
  - An operand with exp==0 is treated as zero (frac ignored; flush-to-zero).
  - An operand with exp==255 and frac==0 is infinity.
  - An operand with exp==255 and frac!=0 is NaN.
- Special-case priority (highest first):
  1. Any NaN, or zero×infinity → canonical quiet NaN 0x7FC00000. Sign is not propagated.
  2. Any infinity → {sign, 8'hFF, 23'h0}.
  3. Any zero → {sign, 31'h0}, i.e. signed zero.
  4. Otherwise, normal path.
- Normal path:
  - Significands: ma = {1, fracA}, mb = {1, fracB}, each 24 bits. Product P = ma×mb, 48 bits, unsigned.
  - Exponent: E = expA + expB − 127, computed in a 10-bit signed intermediate with no wrap.
  - If P[47]==1: mantissa = P[46:24], guard = P[23], sticky = |P[22:0]. E = E+1.
  - Else: mantissa = P[45:23], guard = P[22], sticky = |P[21:0].
  - Round to nearest, ties to even: increment when guard & (sticky | mantissa[0]).
  - If the increment carries out of the 23-bit mantissa, the mantissa becomes 0 and E = E+1.
  - E ≥ 255 after rounding → overflow → {sign, 8'hFF, 23'h0}.
  - E ≤ 0 → underflow → flush to {sign, 31'h0}. No subnormal outputs.
  - Otherwise the result is {sign, E[7:0], mantissa}.
- No status flags are produced. The block is purely combinational between pipeline registers.

## Timing
- Two-stage pipeline. Latency is 2 rising edges from operands to OUT.
- Throughput: one result per cycle.
- Stage 1 (first edge): register sign, special-case code, pre-biased exponent E, and the 48-bit product P.
- Stage 2 (second edge): normalize, round, and pack into the OUT register.
- If inputs are held constant, OUT is stable from the second edge onward.
- Back-to-back different operands appear on OUT in order, one per cycle, each 2 cycles after its inputs.
- Reset behaviour:
  - rst_n low clears all pipeline registers and drives OUT = 32'h00000000 immediately, independent of clk.
  - Reset asserted mid-operation discards all in-flight results.
  - After release, the first valid OUT appears on the second rising edge following release.
  - OUT stays 0 until then.
- No combinational path from IN1/IN2 to OUT.

## Test plan
- IN1=0x415A0000 (13.625), IN2=0xBE200000 (−0.15625), held constant, 40 ns clock period, rst_n released after reset → OUT = 0xC0084000 (−2.12890625) from the 2nd edge after release onward; 0x00000000 before that.
- Specials:
  - 0x7F800000 × 0x00000000 → 0x7FC00000.
  - 0xFF800000 × 0x40000000 → 0xFF800000.
  - 0x80000000 × 0x3F800000 → 0x80000000.
  - 0x00400000 (subnormal) × 0x3F800000 → 0x00000000.
- Overflow/underflow:
  - 0x7F000000 × 0x40000000 → 0x7F800000.
  - 0x00800000 × 0x3F000000 → 0x00000000 (flushed).
- Rounding:
  - 0x3F800001 × 0x3F800001 → 0x3F800002.
  - 0x3FFFFFFF × 0x3FFFFFFF → 0x407FFFFE.
  - 0x3F800000 × 0x3F800000 → 0x3F800000.
- Pipelining: apply a different operand pair on each of 4 consecutive cycles → OUT shows each expected product exactly 2 cycles after its inputs, in order, with no bubbles.
- Async reset mid-stream: assert rst_n low between clock edges while results are streaming → OUT = 0 immediately. Release → OUT = 0 until the 2nd edge after release, then correct products resume.
